// File: rtl/alu_serial_wide.sv
// Serial-framed ALU: collects B/A operand bytes and a command over sin, returns
// the result bytes, flags and CRC3 (or a one-hot error packet) over sout.
module alu_serial_wide #(
    parameter int N_BYTES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic sout,
    output logic busy
);
    localparam int W       = 8 * N_BYTES;
    localparam int N_DATA  = 2 * N_BYTES;
    localparam int FRAME_W = 11 * (N_BYTES + 1);
    localparam int CNT_W   = $clog2(N_DATA + 1);
    localparam int TXC_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {IDLE, RX_BITS, CHECK, EXEC, ERR_TX, TX, RESYNC} state_t;

    state_t             state_q, state_d;
    logic [3:0]         rx_cnt;
    logic               rx_type;
    logic [6:0]         rx_payload;
    logic [2*W-1:0]     opnd;
    logic [CNT_W-1:0]   pkt_cnt;
    logic [3:0]         crc4;
    logic               err_data, bad_stop;
    logic [2:0]         err_code;
    logic [FRAME_W-1:0] tx_sr;
    logic [TXC_W-1:0]   tx_left;

    logic               stop_bad, cnt_full, pkt_err;
    logic [2:0]         op, err_next;
    logic               op_ok;
    logic [W-1:0]       b_op, a_op, res;
    logic [W:0]         sum, dif;
    logic               cy, ov;
    logic [3:0]         flags;
    logic [2:0]         crc3;
    logic [FRAME_W-1:0] frame;
    logic [10:0]        err_pkt;

    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    function automatic logic [2:0] crc3_step(input logic [2:0] c, input logic d);
        logic fb;
        fb = c[2] ^ d;
        return {c[1], c[0] ^ fb, fb};
    endfunction

    // Decisions taken on the stop-bit cycle of a received packet.
    assign stop_bad = !sin;
    assign cnt_full = (pkt_cnt == CNT_W'(N_DATA));
    assign pkt_err  = stop_bad || (rx_type ? !cnt_full : cnt_full);
    assign op       = rx_payload[6:4];

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        b_op  = opnd[2*W-1:W];
        a_op  = opnd[W-1:0];
        sum   = {1'b0, b_op} + {1'b0, a_op};
        dif   = {1'b0, b_op} - {1'b0, a_op};
        res   = '0;
        cy    = 1'b0;
        ov    = 1'b0;
        op_ok = 1'b1;
        case (op)
            3'b000: res = b_op & a_op;
            3'b001: res = b_op | a_op;
            3'b010: res = b_op ^ a_op;
            3'b100: begin
                res = sum[W-1:0];
                cy  = sum[W];
                ov  = (b_op[W-1] == a_op[W-1]) && (res[W-1] != b_op[W-1]);
            end
            3'b101: begin
                res = dif[W-1:0];
                cy  = dif[W];
                ov  = (b_op[W-1] != a_op[W-1]) && (res[W-1] != b_op[W-1]);
            end
            default: op_ok = 1'b0;
        endcase
        flags = {cy, ov, res == '0, res[W-1]};

        crc3 = '0;
        for (int i = W - 1; i >= 0; i--) crc3 = crc3_step(crc3, res[i]);
        crc3 = crc3_step(crc3, 1'b0);
        for (int i = 3; i >= 0; i--) crc3 = crc3_step(crc3, flags[i]);

        frame = '1;
        for (int i = 0; i < N_BYTES; i++)
            frame[FRAME_W-1-11*i -: 11] = {2'b00, res[W-1-8*i -: 8], 1'b1};
        frame[10:0] = {2'b01, 1'b0, flags, crc3, 1'b1};

        if (err_data)                 err_next = 3'b100;
        else if (crc4 != rx_payload[3:0]) err_next = 3'b010;
        else if (!op_ok)              err_next = 3'b001;
        else                          err_next = 3'b000;

        err_pkt = {2'b01, 1'b1, err_code, err_code, ^{1'b1, err_code, err_code}, 1'b1};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (!sin) state_d = RX_BITS;
            RX_BITS:     if (rx_cnt == 4'd9) state_d = (pkt_err || rx_type) ? CHECK : IDLE;
            CHECK:       state_d = (err_next != 3'b000) ? ERR_TX : EXEC;
            EXEC, ERR_TX: state_d = TX;
            TX:          if (tx_left == '0) state_d = bad_stop ? RESYNC : IDLE;
            RESYNC:      if (sin) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CHECK) || (state_q == EXEC) || (state_q == ERR_TX) || (state_q == TX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_cnt     <= '0;
            rx_type    <= 1'b0;
            rx_payload <= '0;
            opnd       <= '0;
            pkt_cnt    <= '0;
            crc4       <= '0;
            err_data   <= 1'b0;
            bad_stop   <= 1'b0;
            err_code   <= '0;
            tx_sr      <= '1;
            tx_left    <= '0;
            sout       <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: rx_cnt <= '0;
                RX_BITS: begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd0) begin
                        rx_type <= sin;
                    end else if (rx_cnt <= 4'd8) begin
                        rx_payload <= {rx_payload[5:0], sin};
                        if (!rx_type) opnd <= {opnd[2*W-2:0], sin};
                        // The CTL reserved bit position stands in for the constant 1 in the CRC4 string.
                        if (!rx_type || rx_cnt <= 4'd4)
                            crc4 <= crc4_step(crc4, (rx_type && rx_cnt == 4'd1) ? 1'b1 : sin);
                    end else if (pkt_err) begin
                        err_data <= 1'b1;
                        bad_stop <= stop_bad;
                    end else if (!rx_type) begin
                        pkt_cnt <= pkt_cnt + CNT_W'(1);
                    end
                end
                CHECK: err_code <= err_next;
                EXEC: begin
                    sout    <= frame[FRAME_W-1];
                    tx_sr   <= {frame[FRAME_W-2:0], 1'b1};
                    tx_left <= TXC_W'(FRAME_W - 1);
                end
                ERR_TX: begin
                    sout    <= err_pkt[10];
                    tx_sr   <= {err_pkt[9:0], {(FRAME_W - 10){1'b1}}};
                    tx_left <= TXC_W'(10);
                end
                TX: begin
                    if (tx_left == '0) begin
                        sout     <= 1'b1;
                        opnd     <= '0;
                        pkt_cnt  <= '0;
                        crc4     <= '0;
                        err_data <= 1'b0;
                        bad_stop <= 1'b0;
                    end else begin
                        sout    <= tx_sr[FRAME_W-1];
                        tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b1};
                        tx_left <= tx_left - TXC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_wide.sv
// Bench for alu_serial_wide: directed vector table, multi-cycle corner sequences
// and random commands checked against an arithmetic reference model.
module tb_alu_serial_wide;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin_drv = 1'b1;
    int   sel = 0;
    logic sin4, sin8, sout4, sout8, busy4, busy8, sout_m, busy_m;

    always #5 clk = ~clk;

    assign sin4   = (sel == 0) ? sin_drv : 1'b1;
    assign sin8   = (sel == 1) ? sin_drv : 1'b1;
    assign sout_m = (sel == 1) ? sout8 : sout4;
    assign busy_m = (sel == 1) ? busy8 : busy4;

    alu_serial_wide #(.N_BYTES(4)) dut4 (.clk(clk), .rst(rst), .sin(sin4), .sout(sout4), .busy(busy4));
    alu_serial_wide #(.N_BYTES(8)) dut8 (.clk(clk), .rst(rst), .sin(sin8), .sout(sout8), .busy(busy8));

    typedef struct packed {
        int           nb;
        logic [127:0] b;
        logic [127:0] a;
        logic [2:0]   op;
        logic         flip;
        int           n_data;
        logic         has_ctl;
        logic         bad_stop;
        int           hold;
        logic [127:0] c;
        logic [3:0]   flags;
        logic [2:0]   err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    bit drv_q[$];
    bit exp_q[$];
    bit crc_msg[$];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int nb, input logic [127:0] b, input logic [127:0] a,
                                input logic [2:0] op, input logic flip, input int n_data,
                                input logic has_ctl, input logic bad_stop, input int hold,
                                input logic [127:0] c, input logic [3:0] flags, input logic [2:0] err);
        vec_t v;
        v.nb = nb; v.b = b; v.a = a; v.op = op; v.flip = flip; v.n_data = n_data;
        v.has_ctl = has_ctl; v.bad_stop = bad_stop; v.hold = hold;
        v.c = c; v.flags = flags; v.err = err;
        return v;
    endfunction

    function automatic logic [127:0] mask_w(input int nb);
        logic [127:0] one = 128'd1;
        return (nb == 16) ? '1 : ((one << (8 * nb)) - 128'd1);
    endfunction

    // CRC as the remainder of polynomial long division of msg * x^k.
    function automatic logic [3:0] poly_rem(input int k, input logic [4:0] poly);
        bit m[$];
        logic [3:0] r = '0;
        m = crc_msg;
        for (int i = 0; i < k; i++) m.push_back(1'b0);
        for (int i = 0; i < crc_msg.size(); i++)
            if (m[i]) for (int j = 0; j <= k; j++) m[i+j] ^= poly[k-j];
        for (int j = 0; j < k; j++) r = {r[2:0], m[crc_msg.size()+j]};
        return r;
    endfunction

    function automatic void model_alu(input int nb, input logic [127:0] b, input logic [127:0] a,
                                      input logic [2:0] op, output logic [127:0] c,
                                      output logic [3:0] flags, output logic [2:0] err);
        int w = 8 * nb;
        logic [128:0] wide;
        logic signed [130:0] sb, sa, sr, lim;
        logic carry = 1'b0, ovf = 1'b0;
        sb = $signed({3'b000, b});
        sa = $signed({3'b000, a});
        if (b[w-1]) sb = sb - (131'sd1 <<< w);
        if (a[w-1]) sa = sa - (131'sd1 <<< w);
        lim = 131'sd1 <<< (w - 1);
        err = 3'b000;
        c = '0;
        case (op)
            3'b000: c = b & a;
            3'b001: c = b | a;
            3'b010: c = b ^ a;
            3'b100: begin
                wide = {1'b0, b} + {1'b0, a};
                c = wide[127:0] & mask_w(nb);
                carry = wide[w];
                sr = sb + sa;
                ovf = (sr >= lim) || (sr < -lim);
            end
            3'b101: begin
                c = (b - a) & mask_w(nb);
                carry = (a > b);
                sr = sb - sa;
                ovf = (sr >= lim) || (sr < -lim);
            end
            default: err = 3'b001;
        endcase
        flags = {carry, ovf, c == '0, c[w-1]};
    endfunction

    task automatic push_drv(input logic [10:0] p);
        for (int i = 10; i >= 0; i--) drv_q.push_back(p[i]);
    endtask

    task automatic push_exp(input logic [10:0] p);
        for (int i = 10; i >= 0; i--) exp_q.push_back(p[i]);
    endtask

    task automatic run_vec(input vec_t v, input int abort_at);
        int w = 8 * v.nb;
        int L;
        logic [7:0] byt;
        logic [3:0] crc;
        logic [2:0] crc3;
        logic [6:0] ep;
        logic pre_busy = 1'b0;
        logic [255:0] got_v = '0, exp_v = '0, bsy_v = '0, exp_b, one = 256'd1;
        sel = (v.nb == 8) ? 1 : 0;
        drv_q.delete();
        exp_q.delete();

        for (int j = 0; j < v.n_data; j++) begin
            if (j < v.nb)          byt = 8'(v.b >> (8 * (v.nb - 1 - j)));
            else if (j < 2 * v.nb) byt = 8'(v.a >> (8 * (2 * v.nb - 1 - j)));
            else                   byt = 8'h00;
            push_drv({2'b00, byt, !(v.bad_stop && j == v.n_data - 1)});
        end
        if (v.has_ctl) begin
            crc_msg.delete();
            for (int i = w - 1; i >= 0; i--) crc_msg.push_back(v.b[i]);
            for (int i = w - 1; i >= 0; i--) crc_msg.push_back(v.a[i]);
            crc_msg.push_back(1'b1);
            for (int i = 2; i >= 0; i--) crc_msg.push_back(v.op[i]);
            crc = poly_rem(4, 5'b10011) ^ {3'b000, v.flip};
            push_drv({2'b01, 1'b0, v.op, crc, 1'b1});
        end

        if (v.err != 3'b000) begin
            ep = {1'b1, v.err, v.err};
            push_exp({2'b01, ep, ^ep, 1'b1});
        end else begin
            for (int j = 0; j < v.nb; j++) push_exp({2'b00, 8'(v.c >> (8 * (v.nb - 1 - j))), 1'b1});
            crc_msg.delete();
            for (int i = w - 1; i >= 0; i--) crc_msg.push_back(v.c[i]);
            crc_msg.push_back(1'b0);
            for (int i = 3; i >= 0; i--) crc_msg.push_back(v.flags[i]);
            crc3 = 3'(poly_rem(3, 5'b01011));
            push_exp({2'b01, 1'b0, v.flags, crc3, 1'b1});
        end
        L = exp_q.size();
        exp_v = {254'd0, 2'b11};
        foreach (exp_q[i]) exp_v = {exp_v[254:0], exp_q[i]};
        exp_v = {exp_v[254:0], 1'b1};
        exp_b = ((one << (L + 2)) - one) << 1;

        for (int i = 0; i < drv_q.size(); i++) begin
            @(negedge clk);
            sin_drv = drv_q[i];
            if (i == drv_q.size() - 1) pre_busy = busy_m;
        end
        @(posedge clk);
        for (int k = 0; k < L + 3; k++) begin
            @(negedge clk);
            sin_drv = (k < v.hold) ? 1'b0 : 1'b1;
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_abort", {sout_m, busy_m}, 2'b10);
                rst = 1'b0;
                sin_drv = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
            got_v = {got_v[254:0], sout_m};
            bsy_v = {bsy_v[254:0], busy_m};
        end
        sin_drv = 1'b1;
        check("busy_idle", pre_busy, 1'b0);
        check("resp", got_v, exp_v);
        check("busy_win", bsy_v, exp_b);
        repeat (3) @(negedge clk);
    endtask

    vec_t tbl[14];
    vec_t rv;
    logic [2:0] ops[8];

    initial begin
        tbl[0]  = mk(4, 128'h2, 128'h3, 3'b100, 0, 8, 1, 0, 0, 128'h5, 4'b0000, 3'b000);
        tbl[1]  = mk(4, 128'h80000000, 128'h1, 3'b101, 0, 8, 1, 0, 0, 128'h7FFFFFFF, 4'b0100, 3'b000);
        tbl[2]  = mk(4, 128'h0, 128'h1, 3'b101, 0, 8, 1, 0, 0, 128'hFFFFFFFF, 4'b1001, 3'b000);
        tbl[3]  = mk(8, 128'hF0F0F0F0F0F0F0F0, 128'hFFFFFFFFFFFFFFFF, 3'b010, 0, 16, 1, 0, 0,
                     128'h0F0F0F0F0F0F0F0F, 4'b0000, 3'b000);
        tbl[4]  = mk(4, 128'hFFFFFFFF, 128'h1, 3'b100, 0, 8, 1, 0, 0, 128'h0, 4'b1010, 3'b000);
        tbl[5]  = mk(4, 128'h7FFFFFFF, 128'h1, 3'b100, 0, 8, 1, 0, 0, 128'h80000000, 4'b0101, 3'b000);
        tbl[6]  = mk(4, 128'h12, 128'h34, 3'b111, 0, 8, 1, 0, 0, 128'h0, 4'b0000, 3'b001);
        tbl[7]  = mk(4, 128'h12, 128'h34, 3'b011, 0, 8, 1, 0, 0, 128'h0, 4'b0000, 3'b001);
        tbl[8]  = mk(4, 128'h12, 128'h34, 3'b100, 1, 8, 1, 0, 0, 128'h0, 4'b0000, 3'b010);
        tbl[9]  = mk(4, 128'h12, 128'h34, 3'b111, 1, 7, 1, 0, 0, 128'h0, 4'b0000, 3'b100);
        tbl[10] = mk(4, 128'h12, 128'h34, 3'b100, 0, 9, 0, 0, 0, 128'h0, 4'b0000, 3'b100);
        tbl[11] = mk(4, 128'hAB, 128'h0, 3'b000, 0, 1, 0, 1, 5, 128'h0, 4'b0000, 3'b100);
        tbl[12] = mk(4, 128'hF0F0F0F0, 128'hFF00FF00, 3'b000, 0, 8, 1, 0, 0, 128'hF000F000, 4'b0001, 3'b000);
        tbl[13] = mk(4, 128'h12340000, 128'h00005678, 3'b001, 0, 8, 1, 0, 0, 128'h12345678, 4'b0000, 3'b000);
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b100, 3'b101, 3'b011};

        repeat (3) @(negedge clk);
        check("reset_state", {sout4, busy4, sout8, busy8}, 4'b1010);
        rst = 1'b0;
        @(negedge clk);
        check("reset_idle", {sout4, busy4, sout8, busy8}, 4'b1010);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], -1);

        // Reset while the second result byte is on the wire, then a clean OR.
        run_vec(tbl[0], 2 + 11 + 4);
        run_vec(tbl[13], -1);

        for (int i = 0; i < 30; i++) begin
            rv = mk(($urandom_range(0, 1) == 1) ? 8 : 4, '0, '0, ops[$urandom_range(0, 7)],
                    ($urandom_range(0, 7) == 0), 0, 1, 0, 0, '0, '0, '0);
            rv.n_data = 2 * rv.nb;
            rv.b = {$urandom(), $urandom(), $urandom(), $urandom()} & mask_w(rv.nb);
            rv.a = {$urandom(), $urandom(), $urandom(), $urandom()} & mask_w(rv.nb);
            case ($urandom_range(0, 3))
                0: rv.a = rv.b;
                1: rv.b = mask_w(rv.nb);
                default: ;
            endcase
            model_alu(rv.nb, rv.b, rv.a, rv.op, rv.c, rv.flags, rv.err);
            if (rv.flip) rv.err = 3'b010;
            run_vec(rv, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
